// File: rtl/credit_bcd_accum_pkg.sv
// Shared constants, encodings and helpers for the coin credit accumulator
// and its double-dabble binary-to-BCD converter.
package credit_bcd_accum_pkg;

  localparam int unsigned MaxCreditDefault = 999;
  localparam int unsigned DdBitsDefault    = 10;
  localparam int unsigned CreditW          = 10;
  localparam int unsigned BcdW             = 12;

  typedef enum logic [1:0] {
    CoinNickel  = 2'd0,
    CoinDime    = 2'd1,
    CoinQuarter = 2'd2,
    CoinDollar  = 2'd3
  } coin_sel_e;

  localparam logic [CreditW-1:0] CentsNickel  = 10'd5;
  localparam logic [CreditW-1:0] CentsDime    = 10'd10;
  localparam logic [CreditW-1:0] CentsQuarter = 10'd25;
  localparam logic [CreditW-1:0] CentsDollar  = 10'd100;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StDone
  } dd_state_e;

  function automatic logic [CreditW-1:0] coin_cents(logic [1:0] sel);
    logic [CreditW-1:0] cents;
    unique case (sel)
      CoinNickel:  cents = CentsNickel;
      CoinDime:    cents = CentsDime;
      CoinQuarter: cents = CentsQuarter;
      default:     cents = CentsDollar;
    endcase
    return cents;
  endfunction

  // Add-3 correction applied to every BCD digit of 5 or more before a shift.
  function automatic logic [BcdW-1:0] dd_adjust(logic [BcdW-1:0] bcd);
    logic [BcdW-1:0] res;
    for (int i = 0; i < BcdW / 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/credit_bcd_accum_if.sv
// Coin/price request bus and credit/display result bus of the credit accumulator.
interface credit_bcd_accum_if;
  import credit_bcd_accum_pkg::*;

  logic               coin_valid;
  logic [1:0]         coin_sel;
  logic [CreditW-1:0] price;
  logic               check_req;
  logic               clear;
  logic [CreditW-1:0] credit;
  logic               coin_reject;
  logic               usd_invalid;
  logic               paid;
  logic [CreditW-1:0] change;
  logic [BcdW-1:0]    x_bcd;
  logic               bcd_valid;

  modport master (
    output coin_valid, coin_sel, price, check_req, clear,
    input  credit, coin_reject, usd_invalid, paid, change, x_bcd, bcd_valid
  );

  modport slave (
    input  coin_valid, coin_sel, price, check_req, clear,
    output credit, coin_reject, usd_invalid, paid, change, x_bcd, bcd_valid
  );

endinterface

// File: rtl/credit_bcd_accum_bcd_dd10.sv
// Sequential double-dabble: converts a DD_BITS-wide binary snapshot into three BCD
// digits, one shift per cycle. bcd is only written once the conversion is complete.
module credit_bcd_accum_bcd_dd10
  import credit_bcd_accum_pkg::*;
#(
  parameter int unsigned DD_BITS = DdBitsDefault
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DD_BITS-1:0] bin,
  output logic [BcdW-1:0]    bcd,
  output logic               done,
  output logic               idle
);

  localparam int unsigned CntW = (DD_BITS > 1) ? $clog2(DD_BITS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DD_BITS - 1);

  dd_state_e             state_q;
  logic [DD_BITS-1:0]    bin_q;
  logic [BcdW-1:0]       scratch_q;
  logic [CntW-1:0]       cnt_q;
  logic [BcdW+DD_BITS-1:0] shifted;

  always_comb begin
    shifted = {dd_adjust(scratch_q), bin_q} << 1;
    done    = (state_q == StDone);
    idle    = (state_q == StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd       <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            bin_q     <= bin;
            scratch_q <= '0;
            state_q   <= StLoad;
          end
        end
        StLoad: begin
          cnt_q   <= '0;
          state_q <= StShift;
        end
        StShift: begin
          scratch_q <= shifted[BcdW+DD_BITS-1 -: BcdW];
          bin_q     <= shifted[DD_BITS-1:0];
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            bcd     <= shifted[BcdW+DD_BITS-1 -: BcdW];
            state_q <= StDone;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: rtl/credit_bcd_accum.sv
// Coin credit accumulator with price check and sequential BCD conversion of the credit
// for the seven-segment display driver.
module credit_bcd_accum
  import credit_bcd_accum_pkg::*;
#(
  parameter int unsigned MAX_CREDIT = MaxCreditDefault,
  parameter int unsigned DD_BITS    = DdBitsDefault
) (
  input logic                clk,
  input logic                reset,
  credit_bcd_accum_if.slave  bus
);

  localparam logic [CreditW:0] MaxSum = MAX_CREDIT[CreditW:0];

  logic [CreditW-1:0] credit_q, credit_d;
  logic [CreditW-1:0] change_q, change_d;
  logic               usd_invalid_q, usd_invalid_d;
  logic               reject_q, reject_d;
  logic               paid_q, paid_d;
  logic               pending_q, pending_d;
  logic               bcd_valid_q, bcd_valid_d;
  logic [CreditW:0]   coin_sum;
  logic               coin_fits;
  logic               credit_changed;
  logic               dd_start, dd_done, dd_idle;
  logic [BcdW-1:0]    dd_bcd;

  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_cents(bus.coin_sel)};
  assign coin_fits = (coin_sum <= MaxSum);
  assign dd_start  = pending_q & dd_idle;

  always_comb begin
    credit_d      = credit_q;
    change_d      = change_q;
    usd_invalid_d = usd_invalid_q;
    reject_d      = 1'b0;
    paid_d        = 1'b0;
    if (bus.clear) begin
      // Clear wins: same-cycle coin is dropped silently, same-cycle check ignored.
      credit_d      = '0;
      usd_invalid_d = 1'b0;
    end else begin
      if (bus.coin_valid) begin
        if (coin_fits) begin
          credit_d      = coin_sum[CreditW-1:0];
          usd_invalid_d = 1'b0;
        end else begin
          reject_d = 1'b1;
        end
      end
      // Check uses the pre-edge credit; a same-cycle coin is still accepted above.
      if (bus.check_req) begin
        if (credit_q >= bus.price) begin
          paid_d        = 1'b1;
          change_d      = credit_q - bus.price;
          usd_invalid_d = 1'b0;
        end else begin
          usd_invalid_d = 1'b1;
        end
      end
    end

    credit_changed = (credit_d != credit_q);
    pending_d      = credit_changed | (pending_q & ~dd_start);
    if (credit_changed) begin
      bcd_valid_d = 1'b0;
    end else if (dd_done) begin
      bcd_valid_d = ~pending_q;
    end else begin
      bcd_valid_d = bcd_valid_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_q      <= '0;
      change_q      <= '0;
      usd_invalid_q <= 1'b0;
      reject_q      <= 1'b0;
      paid_q        <= 1'b0;
      pending_q     <= 1'b0;
      bcd_valid_q   <= 1'b1;
    end else begin
      credit_q      <= credit_d;
      change_q      <= change_d;
      usd_invalid_q <= usd_invalid_d;
      reject_q      <= reject_d;
      paid_q        <= paid_d;
      pending_q     <= pending_d;
      bcd_valid_q   <= bcd_valid_d;
    end
  end

  credit_bcd_accum_bcd_dd10 #(
    .DD_BITS (DD_BITS)
  ) u_bcd_dd10 (
    .clk   (clk),
    .reset (reset),
    .start (dd_start),
    .bin   (credit_q),
    .bcd   (dd_bcd),
    .done  (dd_done),
    .idle  (dd_idle)
  );

  assign bus.credit      = credit_q;
  assign bus.change      = change_q;
  assign bus.usd_invalid = usd_invalid_q;
  assign bus.coin_reject = reject_q;
  assign bus.paid        = paid_q;
  assign bus.x_bcd       = dd_bcd;
  assign bus.bcd_valid   = bcd_valid_q;

endmodule
